seq_datapath: RTL and testbench

Parametrised multicycle successor to the RISC datapath: N-entry register file, shifter, ALU, status and writeback mux, plus an internal sequencer so the controller issues one command per start/busy/done handshake instead of driving loada/loadb/loadc/write per cycle. It sits between the instruction decoder/controller and memory. Immediate/memory/PC writebacks take a one-cycle fast path that bypasses the ALU.

---
 rtl/risc_dp_pkg.sv | 37 +++
 rtl/seq_datapath_if.sv | 48 ++++
 rtl/dp_regfile.sv | 39 +++
 rtl/seq_datapath.sv | 176 +++++++++++++++++
 tb/tb_seq_datapath.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/risc_dp_pkg.sv
// Shared encodings for the sequenced RISC datapath.
//   ALUOP_*  : ALU operation select
//   SHIFT_*  : B-operand shift select
//   VSEL_*   : writeback source select
//   state_e  : sequencer states
//   STATUS_* : bit positions inside the 3-bit status word
`timescale 1ns/1ps
package risc_dp_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_AND = 2'b10;
  localparam logic [1:0] ALUOP_NOT = 2'b11;

  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] SHIFT_LSL  = 2'b01;
  localparam logic [1:0] SHIFT_LSR  = 2'b10;
  localparam logic [1:0] SHIFT_ASR  = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam int unsigned STATUS_Z = 0;
  localparam int unsigned STATUS_N = 1;
  localparam int unsigned STATUS_V = 2;

  typedef enum logic [2:0] {
    StIdle,
    StReadA,
    StReadB,
    StExec,
    StWb
  } state_e;

endpackage

// File: rtl/seq_datapath_if.sv
// Command/response bundle between controller (master) and datapath (slave).
//   Command : start, rn, rm, rd, shift, aluop, asel, bsel, vsel, wr_en, wr_status,
//             mdata, sximm5, sximm8, pc
//   Response: busy, done, status, datapath_out
//   Debug   : dbg_sel -> dbg_data (combinational register read)
`timescale 1ns/1ps
interface seq_datapath_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NREGS   = 8,
  parameter int unsigned PCWIDTH = 8
);
  localparam int unsigned RSEL = $clog2(NREGS);

  logic               start;
  logic [RSEL-1:0]    rn;
  logic [RSEL-1:0]    rm;
  logic [RSEL-1:0]    rd;
  logic [1:0]         shift;
  logic [1:0]         aluop;
  logic               asel;
  logic               bsel;
  logic [1:0]         vsel;
  logic               wr_en;
  logic               wr_status;
  logic [WIDTH-1:0]   mdata;
  logic [WIDTH-1:0]   sximm5;
  logic [WIDTH-1:0]   sximm8;
  logic [PCWIDTH-1:0] pc;
  logic               busy;
  logic               done;
  logic [2:0]         status;
  logic [WIDTH-1:0]   datapath_out;
  logic [RSEL-1:0]    dbg_sel;
  logic [WIDTH-1:0]   dbg_data;

  modport master (
    output start, rn, rm, rd, shift, aluop, asel, bsel, vsel, wr_en, wr_status,
           mdata, sximm5, sximm8, pc, dbg_sel,
    input  busy, done, status, datapath_out, dbg_data
  );

  modport slave (
    input  start, rn, rm, rd, shift, aluop, asel, bsel, vsel, wr_en, wr_status,
           mdata, sximm5, sximm8, pc, dbg_sel,
    output busy, done, status, datapath_out, dbg_data
  );

endinterface

// File: rtl/dp_regfile.sv
// NREGS x WIDTH register file, async active-high reset to zero.
//   clk_i, rst_i            : clock / reset
//   we_i, waddr_i, wdata_i  : single write port (rising edge)
//   raddr_{a,b,dbg}_i       : three combinational read addresses
//   rdata_{a,b,dbg}_o       : matching read data
`timescale 1ns/1ps
module dp_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  localparam int unsigned RSEL = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [RSEL-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [RSEL-1:0]  raddr_a_i,
  input  logic [RSEL-1:0]  raddr_b_i,
  input  logic [RSEL-1:0]  raddr_dbg_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o,
  output logic [WIDTH-1:0] rdata_dbg_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = regs_q[raddr_a_i];
  assign rdata_b_o   = regs_q[raddr_b_i];
  assign rdata_dbg_o = regs_q[raddr_dbg_i];

endmodule

// File: rtl/seq_datapath.sv
// Multicycle RISC datapath with an internal sequencer: one command per
// start/busy/done handshake. ALU commands (vsel=C) walk READ_A, READ_B, EXEC,
// WB; immediate/memory/pc writebacks go straight to WB.
//   clk, reset : clock, async active-high reset
//   bus        : seq_datapath_if slave (command, busy/done, status, C, debug read)
`timescale 1ns/1ps
module seq_datapath
  import risc_dp_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NREGS   = 8,
  parameter int unsigned PCWIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  seq_datapath_if.slave bus
);
  localparam int unsigned RSEL = $clog2(NREGS);

  state_e             state_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   a_q, b_q, c_q;
  logic [2:0]         status_q;

  // Command latch, captured on the accepting edge
  logic [RSEL-1:0]    rn_q, rm_q, rd_q;
  logic [1:0]         shift_q, aluop_q, vsel_q;
  logic               asel_q, bsel_q, wr_en_q, wr_status_q;
  logic [WIDTH-1:0]   mdata_q, sximm5_q, sximm8_q;
  logic [PCWIDTH-1:0] pc_q;

  logic [WIDTH-1:0]   rf_a, rf_b, b_shift, ain, bin, alu_res, wb_data;
  logic [2:0]         alu_status;
  logic               rf_we;

  dp_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i       (clk),
    .rst_i       (reset),
    .we_i        (rf_we),
    .waddr_i     (rd_q),
    .wdata_i     (wb_data),
    .raddr_a_i   (rn_q),
    .raddr_b_i   (rm_q),
    .raddr_dbg_i (bus.dbg_sel),
    .rdata_a_o   (rf_a),
    .rdata_b_o   (rf_b),
    .rdata_dbg_o (bus.dbg_data)
  );

  always_comb begin
    unique case (shift_q)
      SHIFT_LSL: b_shift = {b_q[WIDTH-2:0], 1'b0};
      SHIFT_LSR: b_shift = {1'b0, b_q[WIDTH-1:1]};
      SHIFT_ASR: b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default:   b_shift = b_q;
    endcase
    ain = asel_q ? '0 : a_q;
    bin = bsel_q ? sximm5_q : b_shift;

    alu_res    = '0;
    alu_status = '0;
    unique case (aluop_q)
      ALUOP_ADD: begin
        alu_res = ain + bin;
        alu_status[STATUS_V] = (ain[WIDTH-1] == bin[WIDTH-1]) &&
                               (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      ALUOP_SUB: begin
        alu_res = ain - bin;
        alu_status[STATUS_V] = (ain[WIDTH-1] != bin[WIDTH-1]) &&
                               (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      ALUOP_AND: alu_res = ain & bin;
      default:   alu_res = ~bin;
    endcase
    alu_status[STATUS_Z] = (alu_res == '0);
    alu_status[STATUS_N] = alu_res[WIDTH-1];

    unique case (vsel_q)
      VSEL_PC:    wb_data = WIDTH'(pc_q);
      VSEL_IMM8:  wb_data = sximm8_q;
      VSEL_MDATA: wb_data = mdata_q;
      default:    wb_data = c_q;
    endcase
  end

  // The write lands on the edge that leaves WB
  assign rf_we = (state_q == StWb) && wr_en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      status_q    <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      rd_q        <= '0;
      shift_q     <= '0;
      aluop_q     <= '0;
      vsel_q      <= '0;
      asel_q      <= 1'b0;
      bsel_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_status_q <= 1'b0;
      mdata_q     <= '0;
      sximm5_q    <= '0;
      sximm8_q    <= '0;
      pc_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            rn_q        <= bus.rn;
            rm_q        <= bus.rm;
            rd_q        <= bus.rd;
            shift_q     <= bus.shift;
            aluop_q     <= bus.aluop;
            vsel_q      <= bus.vsel;
            asel_q      <= bus.asel;
            bsel_q      <= bus.bsel;
            wr_en_q     <= bus.wr_en;
            wr_status_q <= bus.wr_status;
            mdata_q     <= bus.mdata;
            sximm5_q    <= bus.sximm5;
            sximm8_q    <= bus.sximm8;
            pc_q        <= bus.pc;
            busy_q      <= 1'b1;
            if (bus.vsel == VSEL_C) begin
              state_q <= StReadA;
            end else begin
              state_q <= StWb;
              done_q  <= 1'b1;
            end
          end
        end
        StReadA: begin
          a_q     <= rf_a;
          state_q <= StReadB;
        end
        StReadB: begin
          b_q     <= rf_b;
          state_q <= StExec;
        end
        StExec: begin
          c_q <= alu_res;
          if (wr_status_q) status_q <= alu_status;
          state_q <= StWb;
          done_q  <= 1'b1;
        end
        StWb: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.status       = status_q;
  assign bus.datapath_out = c_q;

endmodule

// File: tb/tb_seq_datapath.sv
`timescale 1ns/1ps
module tb_seq_datapath;
  import risc_dp_pkg::*;

  typedef struct {
    logic [2:0]  rn, rm, rd;
    logic [1:0]  shift, aluop, vsel;
    logic        asel, bsel, wr_en, wr_status;
    logic [15:0] mdata, sximm5, sximm8;
    logic [7:0]  pc;
  } cmd_t;

  typedef struct {
    int          lat;
    logic [15:0] c;
    logic [2:0]  status;
    logic [2:0]  rd;
    logic        wr_en;
    logic [15:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] mreg [8];
  logic [15:0] mc;
  logic [2:0]  mstat;
  exp_t        sb [$];

  seq_datapath_if #(.WIDTH(16), .NREGS(8), .PCWIDTH(8)) bus ();

  seq_datapath #(.WIDTH(16), .NREGS(8), .PCWIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic cmd_t blank();
    cmd_t c;
    c = '{rn: 3'd0, rm: 3'd0, rd: 3'd0, shift: SHIFT_NONE, aluop: ALUOP_ADD, vsel: VSEL_C,
          asel: 1'b0, bsel: 1'b0, wr_en: 1'b0, wr_status: 1'b0, mdata: 16'h0, sximm5: 16'h0,
          sximm8: 16'h0, pc: 8'h0};
    return c;
  endfunction

  function automatic cmd_t fast(input logic [1:0] vsel, input logic [2:0] rd,
                                input logic [15:0] val);
    cmd_t c;
    c = blank();
    c.vsel = vsel; c.rd = rd; c.wr_en = 1'b1;
    c.sximm8 = val; c.mdata = val; c.pc = val[7:0];
    return c;
  endfunction

  function automatic cmd_t alu(input logic [2:0] rn, rm, rd, input logic [1:0] shift, aluop,
                               input logic asel, bsel, wr_en, wr_status,
                               input logic [15:0] imm5);
    cmd_t c;
    c = blank();
    c.rn = rn; c.rm = rm; c.rd = rd; c.shift = shift; c.aluop = aluop; c.asel = asel;
    c.bsel = bsel; c.wr_en = wr_en; c.wr_status = wr_status; c.sximm5 = imm5;
    return c;
  endfunction

  // Reference model evaluated against the model register file at issue time
  function automatic exp_t predict(input cmd_t c);
    exp_t e;
    logic [15:0] a, b, r;
    int sa, sb2, wide;
    logic v;
    a = c.asel ? 16'h0 : mreg[c.rn];
    b = mreg[c.rm];
    case (c.shift)
      SHIFT_LSL: b = b << 1;
      SHIFT_LSR: b = b >> 1;
      SHIFT_ASR: b = 16'($signed(b) >>> 1);
      default: ;
    endcase
    if (c.bsel) b = c.sximm5;
    sa = int'($signed(a));
    sb2 = int'($signed(b));
    v = 1'b0;
    case (c.aluop)
      ALUOP_ADD: begin r = a + b; wide = sa + sb2; v = (wide > 32767) || (wide < -32768); end
      ALUOP_SUB: begin r = a - b; wide = sa - sb2; v = (wide > 32767) || (wide < -32768); end
      ALUOP_AND: r = a & b;
      default:   r = ~b;
    endcase
    e.rd = c.rd;
    e.wr_en = c.wr_en;
    if (c.vsel == VSEL_C) begin
      e.lat = 3;
      e.c = r;
      e.status = c.wr_status ? {v, r[15], (r == 16'h0)} : mstat;
      e.wdata = r;
    end else begin
      e.lat = 0;
      e.c = mc;
      e.status = mstat;
      e.wdata = (c.vsel == VSEL_PC) ? {8'h00, c.pc} :
                (c.vsel == VSEL_IMM8) ? c.sximm8 : c.mdata;
    end
    return e;
  endfunction

  task automatic drive(input cmd_t c);
    bus.rn = c.rn; bus.rm = c.rm; bus.rd = c.rd; bus.shift = c.shift; bus.aluop = c.aluop;
    bus.vsel = c.vsel; bus.asel = c.asel; bus.bsel = c.bsel; bus.wr_en = c.wr_en;
    bus.wr_status = c.wr_status; bus.mdata = c.mdata; bus.sximm5 = c.sximm5;
    bus.sximm8 = c.sximm8; bus.pc = c.pc;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    mc = 16'h0;
    mstat = 3'b000;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_sel = 3'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), {16'h0, bus.dbg_data}, {16'h0, mreg[i]});
    end
  endtask

  // mode 0: plain command; 1: extra start pulse during READ_B; 2: reset during EXEC
  task automatic send(input cmd_t c, input int mode);
    exp_t e;
    int cyc;
    @(negedge clk);
    drive(c);
    bus.start = 1'b1;
    e = predict(c);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_accept", {31'h0, bus.busy}, 32'd1);
    cyc = 0;
    while (cyc < 8 && !bus.done) begin
      if (mode == 2 && cyc == 2) begin
        reset = 1'b1;
        #1;
        check("abort_busy", {31'h0, bus.busy}, 32'd0);
        check("abort_done", {31'h0, bus.done}, 32'd0);
        check("abort_status", {29'h0, bus.status}, 32'd0);
        check("abort_out", {16'h0, bus.datapath_out}, 32'd0);
        clear_model();
        check_regs("abort");
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_front());
        return;
      end
      bus.start = (mode == 1 && cyc == 1);
      if (mode == 1 && cyc == 1) begin
        bus.rd = 3'd6; bus.vsel = VSEL_IMM8; bus.sximm8 = 16'h0BAD; bus.wr_en = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("done_latency", cyc, e.lat);
    check("datapath_out", {16'h0, bus.datapath_out}, {16'h0, e.c});
    check("status", {29'h0, bus.status}, {29'h0, e.status});
    @(negedge clk);
    check("done_single", {31'h0, bus.done}, 32'd0);
    check("busy_cleared", {31'h0, bus.busy}, 32'd0);
    if (e.wr_en) mreg[e.rd] = e.wdata;
    mc = e.c;
    mstat = e.status;
    check_regs("regs");
  endtask

  initial begin
    drive(blank());
    bus.start = 1'b0;
    bus.dbg_sel = 3'd0;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'h0, bus.busy}, 32'd0);
    check("reset_done", {31'h0, bus.done}, 32'd0);
    check("reset_status", {29'h0, bus.status}, 32'd0);
    check("reset_out", {16'h0, bus.datapath_out}, 32'd0);
    check_regs("reset");

    send(fast(VSEL_IMM8, 3'd0, 16'h0007), 0);
    send(fast(VSEL_IMM8, 3'd1, 16'h0002), 0);
    // R2 = R0 + (R1 << 1) = 0x000B
    send(alu(3'd0, 3'd1, 3'd2, SHIFT_LSL, ALUOP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0), 0);
    send(fast(VSEL_MDATA, 3'd3, 16'h7FFF), 0);
    send(fast(VSEL_MDATA, 3'd4, 16'hFFFF), 0);
    // CMP 0x7FFF - 0xFFFF: C=0x8000, N=1 V=1, no write
    send(alu(3'd3, 3'd4, 3'd5, SHIFT_NONE, ALUOP_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0), 0);
    // second start during READ_B must be ignored
    send(alu(3'd0, 3'd1, 3'd5, SHIFT_NONE, ALUOP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0), 1);
    send(fast(VSEL_IMM8, 3'd6, 16'h0010), 0);
    send(alu(3'd6, 3'd0, 3'd7, SHIFT_NONE, ALUOP_AND, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFF0), 0);
    send(alu(3'd6, 3'd0, 3'd7, SHIFT_NONE, ALUOP_NOT, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFF0), 0);
    send(alu(3'd0, 3'd4, 3'd5, SHIFT_LSR, ALUOP_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0), 0);
    send(alu(3'd0, 3'd4, 3'd5, SHIFT_ASR, ALUOP_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0), 0);
    send(fast(VSEL_PC, 3'd1, 16'h00A5), 0);
    send(alu(3'd1, 3'd1, 3'd2, SHIFT_NONE, ALUOP_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0), 2);
    send(fast(VSEL_IMM8, 3'd3, 16'h1234), 0);
    send(alu(3'd3, 3'd3, 3'd3, SHIFT_NONE, ALUOP_SUB, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
